// File: rtl/qpu_ifu_ift2icb_ot.sv
// Instruction-fetch to ITCM ICB converter: issues up to OUTS_DEPTH outstanding reads and returns
// 32-bit instructions in order. Define QPU_IFU_LINE_REUSE_EN to enable same-line reuse (fake responses).
module qpu_ifu_ift2icb_ot #(
  parameter int PC_W       = 32,
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 64,
  parameter int OUTS_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ifu_req_valid,
  output logic              ifu_req_ready,
  input  logic [PC_W-1:0]   ifu_req_pc,
  input  logic              ifu_req_seq,
  output logic              ifu_rsp_valid,
  input  logic              ifu_rsp_ready,
  output logic [31:0]       ifu_rsp_instr,
  output logic              ifu_icb_cmd_valid,
  input  logic              ifu_icb_cmd_ready,
  output logic [ADDR_W-1:0] ifu_icb_cmd_addr,
  input  logic              ifu_icb_rsp_valid,
  output logic              ifu_icb_rsp_ready,
  input  logic [DATA_W-1:0] ifu_icb_rsp_rdata,
  input  logic              ifu_holdup,
  input  logic              itcm_nohold
);

  localparam int WB     = $clog2(DATA_W / 8);
  localparam int NW     = DATA_W / 32;
  localparam int IDX_W  = WB - 2;
  localparam int LINE_W = PC_W - WB;
  localparam int PTR_W  = (OUTS_DEPTH > 1) ? $clog2(OUTS_DEPTH) : 1;
  localparam int CNT_W  = $clog2(OUTS_DEPTH) + 1;

  logic [IDX_W-1:0]    req_idx;
  logic [IDX_W-1:0]    head_idx;
  logic [IDX_W-1:0]    idx_mem [OUTS_DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [CNT_W-1:0]    count;
  logic                empty;
  logic                full;
  logic                reuse;
  logic                head_fake;
  logic                push;
  logic                pop;
  logic                cmd_hs;
  logic                icb_rsp_hs;
  logic [31:0]         fake_instr;
  logic [NW-1:0][31:0] rdata_words;
  logic                unused_ok;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(OUTS_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign req_idx     = ifu_req_pc[WB-1:2];
  assign rdata_words = ifu_icb_rsp_rdata;
  assign unused_ok   = ^{ifu_req_pc, ifu_req_seq, ifu_holdup, itcm_nohold};

  // Reset is folded into empty/full so the handshake outputs are defined while rst is high.
  assign empty = rst | (count == '0);
  assign full  = ~rst & (count == CNT_W'(OUTS_DEPTH));

  assign ifu_icb_cmd_valid = ifu_req_valid & ~full & ~reuse;
  assign ifu_icb_cmd_addr  = ifu_req_pc[ADDR_W-1:0];
  assign ifu_req_ready     = ~full & (reuse | ifu_icb_cmd_ready);
  assign ifu_rsp_valid     = ~empty & (head_fake | ifu_icb_rsp_valid);
  assign ifu_icb_rsp_ready = ~empty & ~head_fake & ifu_rsp_ready;

  assign push       = ifu_req_valid & ifu_req_ready;
  assign pop        = ifu_rsp_valid & ifu_rsp_ready;
  assign cmd_hs     = ifu_icb_cmd_valid & ifu_icb_cmd_ready;
  assign icb_rsp_hs = ifu_icb_rsp_valid & ifu_icb_rsp_ready;

  assign head_idx      = idx_mem[rd_ptr];
  assign ifu_rsp_instr = head_fake ? fake_instr : rdata_words[head_idx];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (push & ~pop)      count <= count + 1'b1;
      else if (pop & ~push) count <= count - 1'b1;
    end
  end

  // NOTE: tracking storage is deliberately not reset; the occupancy count alone marks live entries.
  always_ff @(posedge clk) begin
    if (push) idx_mem[wr_ptr] <= req_idx;
  end

`ifdef QPU_IFU_LINE_REUSE_EN
  logic [LINE_W-1:0]   req_line;
  logic [LINE_W-1:0]   last_line;
  logic                last_vld;
  logic [DATA_W-1:0]   line_q;
  logic [NW-1:0][31:0] line_words;
  logic                fake_mem [OUTS_DEPTH];

  assign req_line   = ifu_req_pc[PC_W-1:WB];
  assign reuse      = ~rst & ifu_req_seq & last_vld & (req_line == last_line)
                      & ifu_holdup & ~itcm_nohold;
  assign line_words = line_q;
  assign head_fake  = fake_mem[rd_ptr];
  assign fake_instr = line_words[head_idx];

  // In-order ICB returns guarantee line_q holds last_line's data once a fake entry is at the head.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_line <= '0;
      last_vld  <= 1'b0;
      line_q    <= '0;
    end else begin
      if (cmd_hs) begin
        last_line <= req_line;
        last_vld  <= 1'b1;
      end
      if (icb_rsp_hs) line_q <= ifu_icb_rsp_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fake_mem[wr_ptr] <= reuse;
  end
`else
  logic unused_hs;
  assign unused_hs  = cmd_hs ^ icb_rsp_hs;
  assign reuse      = 1'b0;
  assign head_fake  = 1'b0;
  assign fake_instr = '0;
`endif

endmodule
